// File: rtl/decode_pkg.sv
// Shared decode constants: opcodes, ALU control codes, branch func3 codes.
// Imported by the decode stage and the branch resolver.
package decode_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [3:0] {
    ALU_NONE = 4'd0,
    ALU_ADD  = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_SLL  = 4'd3,
    ALU_SLT  = 4'd4,
    ALU_SLTU = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_SRL  = 4'd7,
    ALU_SRA  = 4'd8,
    ALU_OR   = 4'd9,
    ALU_AND  = 4'd10
  } alu_ctrl_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [31:0] NOP = 32'h00000013;

  // alt selects SUB/SRA; caller masks it for ADDI
  function automatic alu_ctrl_e alu_op(
    input logic [2:0] f3,
    input logic       alt
  );
    unique case (f3)
      3'b000:  alu_op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op = ALU_SLL;
      3'b010:  alu_op = ALU_SLT;
      3'b011:  alu_op = ALU_SLTU;
      3'b100:  alu_op = ALU_XOR;
      3'b101:  alu_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/decode_pipe_branch_resolve.sv
// Branch/jump outcome and target from forwarded operands.
// Next fetch PC is the target when taken, otherwise pc+4.
module branch_resolve
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_is_br,
  input  logic            i_is_jal,
  input  logic            i_is_jalr,
  input  logic [2:0]      i_func3,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_imm,
  output logic            o_taken,
  output logic [XLEN-1:0] o_next_pc
);

  localparam logic [XLEN-1:0] FOUR = XLEN'(4);

  logic            w_cond;
  logic            w_eq;
  logic            w_lt;
  logic            w_ltu;
  logic [XLEN-1:0] w_pc_tgt;
  logic [XLEN-1:0] w_jr_sum;
  logic [XLEN-1:0] w_target;

  assign w_eq  = (i_rs1 == i_rs2);
  assign w_lt  = ($signed(i_rs1) < $signed(i_rs2));
  assign w_ltu = (i_rs1 < i_rs2);

  always_comb begin
    w_cond = 1'b0;
    unique case (i_func3)
      F3_BEQ:  w_cond = w_eq;
      F3_BNE:  w_cond = !w_eq;
      F3_BLT:  w_cond = w_lt;
      F3_BGE:  w_cond = !w_lt;
      F3_BLTU: w_cond = w_ltu;
      F3_BGEU: w_cond = !w_ltu;
      default: w_cond = 1'b0;
    endcase
  end

  assign w_pc_tgt = i_pc + i_imm;
  assign w_jr_sum = i_rs1 + i_imm;
  assign w_target = i_is_jalr ? {w_jr_sum[XLEN-1:1], 1'b0}
                              : w_pc_tgt;

  assign o_taken   = i_is_jal | i_is_jalr | (i_is_br & w_cond);
  assign o_next_pc = o_taken ? w_target : i_pc + FOUR;

endmodule

// File: rtl/decode_pipe.sv
// Decode stage: field/immediate decode, operand forwarding,
// load-use stall, early branch resolution and the EX output register.
module decode_pipe
  import decode_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int NUM_FWD        = 2,
  parameter bit HAS_BR_RESOLVE = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [31:0]             i_instr,
  input  logic [XLEN-1:0]         i_pc,
  input  logic                    i_pred_taken,
  output logic [4:0]              o_rs1_addr,
  output logic [4:0]              o_rs2_addr,
  input  logic [XLEN-1:0]         i_rs1_rdata,
  input  logic [XLEN-1:0]         i_rs2_rdata,
  input  logic [NUM_FWD-1:0]      i_fwd_valid,
  input  logic [5*NUM_FWD-1:0]    i_fwd_rd,
  input  logic [XLEN*NUM_FWD-1:0] i_fwd_data,
  input  logic                    i_ex_is_load,
  input  logic [4:0]              i_ex_rd,
  input  logic                    i_flush,
  output logic                    o_redirect,
  output logic [XLEN-1:0]         o_redirect_pc,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [XLEN-1:0]         o_rs1_data,
  output logic [XLEN-1:0]         o_rs2_data,
  output logic [XLEN-1:0]         o_imm,
  output logic [6:0]              o_opcode,
  output logic [2:0]              o_func3,
  output logic [3:0]              o_alu_ctrl,
  output logic [4:0]              o_rd,
  output logic [XLEN-1:0]         o_pc,
  output logic                    o_illegal
);

  logic [6:0]      w_op;
  logic [2:0]      w_f3;
  logic [4:0]      w_rd;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic            w_is_lui, w_is_auipc, w_is_jal, w_is_jalr;
  logic            w_is_br, w_is_load, w_is_store;
  logic            w_is_imm, w_is_reg, w_alt;
  logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [XLEN-1:0] w_imm;
  logic [3:0]      w_alu;
  logic            w_use1, w_use2, w_has_rd, w_illegal;
  logic [XLEN-1:0] w_rs1_fwd, w_rs2_fwd;
  logic            w_hazard, w_fire, w_accept;
  logic            w_taken, w_mispred;
  logic [XLEN-1:0] w_next_pc;

  logic            r_valid, r_redirect, r_illegal;
  logic [XLEN-1:0] r_redirect_pc, r_rs1, r_rs2, r_imm, r_pc;
  logic [6:0]      r_op;
  logic [2:0]      r_f3;
  logic [3:0]      r_alu;
  logic [4:0]      r_rd;

  assign w_op  = i_instr[6:0];
  assign w_rd  = i_instr[11:7];
  assign w_f3  = i_instr[14:12];
  assign w_rs1 = i_instr[19:15];
  assign w_rs2 = i_instr[24:20];

  assign w_is_lui   = (w_op == OP_LUI);
  assign w_is_auipc = (w_op == OP_AUIPC);
  assign w_is_jal   = (w_op == OP_JAL);
  assign w_is_jalr  = (w_op == OP_JALR);
  assign w_is_br    = (w_op == OP_BRANCH);
  assign w_is_load  = (w_op == OP_LOAD);
  assign w_is_store = (w_op == OP_STORE);
  assign w_is_imm   = (w_op == OP_IMM);
  assign w_is_reg   = (w_op == OP_REG);
  // bit 30 is immediate data for ADDI, only SRAI reads it
  assign w_alt = i_instr[30] & (w_is_reg | (w_f3 == 3'b101));

  assign w_imm_i = {{(XLEN-12){i_instr[31]}}, i_instr[31:20]};
  assign w_imm_s = {{(XLEN-12){i_instr[31]}},
                    i_instr[31:25], i_instr[11:7]};
  assign w_imm_b = {{(XLEN-12){i_instr[31]}}, i_instr[7],
                    i_instr[30:25], i_instr[11:8], 1'b0};
  assign w_imm_u = {{(XLEN-32){i_instr[31]}},
                    i_instr[31:12], 12'b0};
  assign w_imm_j = {{(XLEN-20){i_instr[31]}}, i_instr[19:12],
                    i_instr[20], i_instr[30:21], 1'b0};

  always_comb begin
    w_imm     = '0;
    w_alu     = ALU_NONE;
    w_use1    = 1'b0;
    w_use2    = 1'b0;
    w_has_rd  = 1'b1;
    w_illegal = 1'b0;
    unique case (1'b1)
      w_is_lui, w_is_auipc: begin
        w_imm = w_imm_u;
        w_alu = ALU_ADD;
      end
      w_is_jal: begin
        w_imm = w_imm_j;
        w_alu = ALU_ADD;
      end
      w_is_jalr, w_is_load: begin
        w_imm  = w_imm_i;
        w_alu  = ALU_ADD;
        w_use1 = 1'b1;
      end
      w_is_br: begin
        w_imm    = w_imm_b;
        w_alu    = ALU_SUB;
        w_use1   = 1'b1;
        w_use2   = 1'b1;
        w_has_rd = 1'b0;
      end
      w_is_store: begin
        w_imm    = w_imm_s;
        w_alu    = ALU_ADD;
        w_use1   = 1'b1;
        w_use2   = 1'b1;
        w_has_rd = 1'b0;
      end
      w_is_imm: begin
        w_imm  = w_imm_i;
        w_alu  = alu_op(w_f3, w_alt);
        w_use1 = 1'b1;
      end
      w_is_reg: begin
        w_alu  = alu_op(w_f3, w_alt);
        w_use1 = 1'b1;
        w_use2 = 1'b1;
      end
      default: w_illegal = 1'b1;
    endcase
  end

  // walk oldest to youngest so the lowest index wins
  always_comb begin
    w_rs1_fwd = i_rs1_rdata;
    w_rs2_fwd = i_rs2_rdata;
    for (int k = NUM_FWD-1; k >= 0; k--) begin
      if (i_fwd_valid[k] && i_fwd_rd[5*k +: 5] == w_rs1)
        w_rs1_fwd = i_fwd_data[XLEN*k +: XLEN];
      if (i_fwd_valid[k] && i_fwd_rd[5*k +: 5] == w_rs2)
        w_rs2_fwd = i_fwd_data[XLEN*k +: XLEN];
    end
    if (w_rs1 == 5'd0) w_rs1_fwd = '0;
    if (w_rs2 == 5'd0) w_rs2_fwd = '0;
  end

  assign w_hazard = i_valid & i_ex_is_load & (i_ex_rd != 5'd0)
                  & ((w_use1 & (i_ex_rd == w_rs1))
                   | (w_use2 & (i_ex_rd == w_rs2)));

  assign o_ready  = (!r_valid | i_ready) & !w_hazard;
  assign w_fire   = i_valid & o_ready;
  assign w_accept = w_fire & !r_redirect & !i_flush;

  generate
    if (HAS_BR_RESOLVE) begin : g_br
      branch_resolve #(.XLEN(XLEN)) u_br (
        .i_is_br   (w_is_br),
        .i_is_jal  (w_is_jal),
        .i_is_jalr (w_is_jalr),
        .i_func3   (w_f3),
        .i_rs1     (w_rs1_fwd),
        .i_rs2     (w_rs2_fwd),
        .i_pc      (i_pc),
        .i_imm     (w_imm),
        .o_taken   (w_taken),
        .o_next_pc (w_next_pc)
      );
      assign w_mispred = (w_is_br | w_is_jal | w_is_jalr)
                       & (w_taken ^ i_pred_taken);
    end else begin : g_nobr
      assign w_taken   = 1'b0;
      assign w_next_pc = '0;
      assign w_mispred = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid       <= 1'b0;
      r_redirect    <= 1'b0;
      r_redirect_pc <= '0;
      r_rs1         <= '0;
      r_rs2         <= '0;
      r_imm         <= '0;
      r_pc          <= '0;
      r_op          <= '0;
      r_f3          <= '0;
      r_alu         <= '0;
      r_rd          <= '0;
      r_illegal     <= 1'b0;
    end else begin
      if (i_flush)
        r_valid <= 1'b0;
      else if (!r_valid | i_ready)
        r_valid <= w_accept;
      r_redirect    <= w_accept & w_mispred;
      r_redirect_pc <= w_next_pc;
      if (w_accept) begin
        r_rs1     <= w_rs1_fwd;
        r_rs2     <= w_rs2_fwd;
        r_imm     <= w_imm;
        r_pc      <= i_pc;
        r_op      <= w_op;
        r_f3      <= w_f3;
        r_alu     <= w_alu;
        r_rd      <= w_has_rd ? w_rd : 5'd0;
        r_illegal <= w_illegal;
      end
    end
  end

  assign o_rs1_addr    = w_rs1;
  assign o_rs2_addr    = w_rs2;
  assign o_valid       = r_valid;
  assign o_redirect    = r_redirect;
  assign o_redirect_pc = r_redirect_pc;
  assign o_rs1_data    = r_rs1;
  assign o_rs2_data    = r_rs2;
  assign o_imm         = r_imm;
  assign o_pc          = r_pc;
  assign o_opcode      = r_op;
  assign o_func3       = r_f3;
  assign o_alu_ctrl    = r_alu;
  assign o_rd          = r_rd;
  assign o_illegal     = r_illegal;

endmodule

// File: tb/tb_decode_pipe.sv
// Directed bench for decode_pipe: vector table plus
// stall, hazard, redirect, flush, reset and 64-bit sequences.
module tb_decode_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        i_valid = 0, o_ready;
  logic [31:0] i_instr = 0, i_pc = 0;
  logic        i_pred_taken = 0;
  logic [4:0]  o_rs1_addr, o_rs2_addr;
  logic [31:0] i_rs1_rdata = 0, i_rs2_rdata = 0;
  logic [1:0]  i_fwd_valid = 0;
  logic [9:0]  i_fwd_rd = 0;
  logic [63:0] i_fwd_data = 0;
  logic        i_ex_is_load = 0;
  logic [4:0]  i_ex_rd = 0;
  logic        i_flush = 0, i_ready = 1;
  logic        o_redirect, o_valid, o_illegal;
  logic [31:0] o_redirect_pc, o_rs1_data, o_rs2_data;
  logic [31:0] o_imm, o_pc;
  logic [6:0]  o_opcode;
  logic [2:0]  o_func3;
  logic [3:0]  o_alu_ctrl;
  logic [4:0]  o_rd;

  logic         d_valid = 0, d_ready_o;
  logic [31:0]  d_instr = 0;
  logic [63:0]  d_pc = 0, d_rs1 = 0, d_rs2 = 0;
  logic         d_pred = 0;
  logic [4:0]   d_rs1_addr, d_rs2_addr;
  logic [1:0]   d_fwd_valid = 0;
  logic [9:0]   d_fwd_rd = 0;
  logic [127:0] d_fwd_data = 0;
  logic         d_redirect, d_ovalid, d_illegal;
  logic [63:0]  d_redirect_pc, d_rs1_data, d_rs2_data;
  logic [63:0]  d_imm, d_opc;
  logic [6:0]   d_opcode;
  logic [2:0]   d_func3;
  logic [3:0]   d_alu;
  logic [4:0]   d_rd;

  decode_pipe #(.XLEN(32), .NUM_FWD(2)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .i_valid(i_valid), .o_ready(o_ready),
    .i_instr(i_instr), .i_pc(i_pc),
    .i_pred_taken(i_pred_taken),
    .o_rs1_addr(o_rs1_addr), .o_rs2_addr(o_rs2_addr),
    .i_rs1_rdata(i_rs1_rdata), .i_rs2_rdata(i_rs2_rdata),
    .i_fwd_valid(i_fwd_valid), .i_fwd_rd(i_fwd_rd),
    .i_fwd_data(i_fwd_data),
    .i_ex_is_load(i_ex_is_load), .i_ex_rd(i_ex_rd),
    .i_flush(i_flush),
    .o_redirect(o_redirect), .o_redirect_pc(o_redirect_pc),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_rs1_data(o_rs1_data), .o_rs2_data(o_rs2_data),
    .o_imm(o_imm), .o_opcode(o_opcode), .o_func3(o_func3),
    .o_alu_ctrl(o_alu_ctrl), .o_rd(o_rd), .o_pc(o_pc),
    .o_illegal(o_illegal)
  );

  decode_pipe #(.XLEN(64), .NUM_FWD(2)) u_dut64 (
    .clk(clk), .rst_n(rst_n),
    .i_valid(d_valid), .o_ready(d_ready_o),
    .i_instr(d_instr), .i_pc(d_pc),
    .i_pred_taken(d_pred),
    .o_rs1_addr(d_rs1_addr), .o_rs2_addr(d_rs2_addr),
    .i_rs1_rdata(d_rs1), .i_rs2_rdata(d_rs2),
    .i_fwd_valid(d_fwd_valid), .i_fwd_rd(d_fwd_rd),
    .i_fwd_data(d_fwd_data),
    .i_ex_is_load(1'b0), .i_ex_rd(5'd0),
    .i_flush(1'b0),
    .o_redirect(d_redirect), .o_redirect_pc(d_redirect_pc),
    .o_valid(d_ovalid), .i_ready(1'b1),
    .o_rs1_data(d_rs1_data), .o_rs2_data(d_rs2_data),
    .o_imm(d_imm), .o_opcode(d_opcode), .o_func3(d_func3),
    .o_alu_ctrl(d_alu), .o_rd(d_rd), .o_pc(d_opc),
    .o_illegal(d_illegal)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(
    input logic [11:0] imm, input logic [4:0] rs1,
    input logic [2:0] f3, input logic [4:0] rd,
    input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(
    input logic [6:0] f7, input logic [4:0] rs2,
    input logic [4:0] rs1, input logic [2:0] f3,
    input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_s(
    input logic [11:0] imm, input logic [4:0] rs2,
    input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(
    input logic [12:0] imm, input logic [4:0] rs2,
    input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3,
            imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(
    input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12],
            rd, 7'b1101111};
  endfunction

  typedef struct {
    string       nm;
    logic [31:0] instr, pc, rs1, rs2;
    logic        pred;
    logic [31:0] e_imm;
    logic [4:0]  e_rd;
    logic [3:0]  e_alu;
    logic        e_ill, e_redir;
    logic [31:0] e_rpc, e_rs1;
  } vec_t;

  vec_t v[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins,
                       input logic [31:0] pc);
    i_instr = ins;
    i_pc    = pc;
    i_valid = 1'b1;
  endtask

  initial begin
    v.push_back('{"addi", enc_i(12'd5, 0, 0, 1, 7'b0010011),
      32'h0, 32'h1234, 0, 0, 32'd5, 1, 1, 0, 0, 32'h4, 0});
    v.push_back('{"addi_neg", enc_i(12'hFFF, 1, 0, 2, 7'b0010011),
      32'h4, 32'h77, 0, 0, 32'hFFFF_FFFF, 2, 1, 0, 0,
      32'h8, 32'h77});
    v.push_back('{"sub", enc_r(7'h20, 2, 1, 0, 3),
      32'h8, 32'h10, 32'h3, 0, 32'h0, 3, 2, 0, 0,
      32'hC, 32'h10});
    v.push_back('{"srai", enc_i(12'h405, 1, 5, 4, 7'b0010011),
      32'hC, 32'h10, 0, 0, 32'h405, 4, 8, 0, 0,
      32'h10, 32'h10});
    v.push_back('{"sw", enc_s(12'hFFC, 2, 1, 3'b010),
      32'h10, 32'h20, 0, 0, 32'hFFFF_FFFC, 0, 1, 0, 0,
      32'h14, 32'h20});
    v.push_back('{"lui", {20'h80000, 5'd5, 7'b0110111},
      32'h14, 32'h9, 0, 0, 32'h8000_0000, 5, 1, 0, 0,
      32'h18, 0});
    v.push_back('{"jal_mis", enc_j(21'h800, 1),
      32'h200, 0, 0, 0, 32'h800, 1, 1, 0, 1, 32'hA00, 0});
    v.push_back('{"bne_mis", enc_b(13'h1FF8, 2, 1, 3'b001),
      32'h300, 32'h1, 32'h1, 1, 32'hFFFF_FFF8, 0, 2, 0, 1,
      32'h304, 32'h1});
    v.push_back('{"blt_ok", enc_b(13'h8, 2, 1, 3'b100),
      32'h400, 32'hFFFF_FFFF, 32'h1, 1, 32'h8, 0, 2, 0, 0,
      32'h408, 32'hFFFF_FFFF});
    v.push_back('{"bltu_ok", enc_b(13'h8, 2, 1, 3'b110),
      32'h400, 32'hFFFF_FFFF, 32'h1, 0, 32'h8, 0, 2, 0, 0,
      32'h404, 32'hFFFF_FFFF});
    v.push_back('{"bge_mis", enc_b(13'h10, 2, 1, 3'b101),
      32'h800, 32'h5, 32'h5, 0, 32'h10, 0, 2, 0, 1,
      32'h810, 32'h5});
    v.push_back('{"jal_wrap", enc_j(21'h8, 0),
      32'hFFFF_FFFC, 0, 0, 0, 32'h8, 0, 1, 0, 1, 32'h4, 0});
    v.push_back('{"jalr_ok", enc_i(12'd4, 6, 0, 1, 7'b1100111),
      32'h600, 32'h1001, 0, 1, 32'h4, 1, 1, 0, 0,
      32'h1004, 32'h1001});
    v.push_back('{"illegal", 32'h0000_007F,
      32'h500, 32'h99, 0, 1, 32'h0, 0, 0, 1, 0, 32'h504, 0});
    v.push_back('{"and", enc_r(7'h0, 2, 1, 3'b111, 7),
      32'h700, 32'h5, 32'h6, 0, 32'h0, 7, 10, 0, 0,
      32'h704, 32'h5});

    #1;
    chk("rst_valid", o_valid, 0);
    chk("rst_redirect", o_redirect, 0);
    chk("rst_rpc", o_redirect_pc, 0);
    chk("rst_illegal", o_illegal, 0);
    chk("rst_imm", o_imm, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    foreach (v[n]) begin
      drive(v[n].instr, v[n].pc);
      i_rs1_rdata  = v[n].rs1;
      i_rs2_rdata  = v[n].rs2;
      i_pred_taken = v[n].pred;
      tick();
      i_valid = 1'b0;
      chk({v[n].nm, "_valid"}, o_valid, 1);
      chk({v[n].nm, "_imm"}, o_imm, v[n].e_imm);
      chk({v[n].nm, "_rd"}, o_rd, v[n].e_rd);
      chk({v[n].nm, "_alu"}, o_alu_ctrl, v[n].e_alu);
      chk({v[n].nm, "_ill"}, o_illegal, v[n].e_ill);
      chk({v[n].nm, "_redir"}, o_redirect, v[n].e_redir);
      chk({v[n].nm, "_rpc"}, o_redirect_pc, v[n].e_rpc);
      chk({v[n].nm, "_rs1"}, o_rs1_data, v[n].e_rs1);
      chk({v[n].nm, "_pc"}, o_pc, v[n].pc);
      tick();
    end
    i_pred_taken = 1'b0;

    // load-use stall
    drive(enc_i(12'd5, 0, 0, 1, 7'b0010011), 32'h40);
    tick();
    drive(enc_r(7'h0, 2, 3, 0, 4), 32'h44);
    i_ex_is_load = 1'b1;
    i_ex_rd      = 5'd3;
    #1;
    chk("haz_ready", o_ready, 0);
    tick();
    chk("haz_bubble", o_valid, 0);
    i_ex_is_load = 1'b0;
    #1;
    chk("haz_clear_ready", o_ready, 1);
    tick();
    i_valid = 1'b0;
    chk("haz_issue_valid", o_valid, 1);
    chk("haz_issue_rd", o_rd, 4);
    tick();

    // forwarding priority
    i_fwd_valid = 2'b11;
    i_fwd_rd    = {5'd5, 5'd5};
    i_fwd_data  = {32'hBB, 32'hAA};
    i_rs1_rdata = 32'h55;
    i_rs2_rdata = 32'h66;
    drive(enc_r(7'h0, 5, 5, 0, 6), 32'h80);
    tick();
    chk("fwd_rs1_young", o_rs1_data, 32'hAA);
    chk("fwd_rs2_young", o_rs2_data, 32'hAA);
    i_fwd_rd = {5'd5, 5'd7};
    tick();
    i_valid = 1'b0;
    chk("fwd_rs1_old", o_rs1_data, 32'hBB);
    i_fwd_valid = 2'b00;
    tick();

    // BEQ mispredict, wrong-path drop
    i_rs1_rdata = 32'h42;
    i_rs2_rdata = 32'h42;
    drive(enc_b(13'h10, 2, 1, 3'b000), 32'h100);
    tick();
    chk("beq_redirect", o_redirect, 1);
    chk("beq_rpc", o_redirect_pc, 32'h110);
    drive(enc_i(12'd7, 0, 0, 9, 7'b0010011), 32'h104);
    #1;
    chk("drop_fires", o_ready, 1);
    tick();
    chk("redirect_pulse", o_redirect, 0);
    chk("drop_valid", o_valid, 0);
    drive(enc_i(12'd7, 0, 0, 9, 7'b0010011), 32'h110);
    tick();
    i_valid = 1'b0;
    chk("after_drop_valid", o_valid, 1);
    chk("after_drop_pc", o_pc, 32'h110);

    // backpressure then flush
    drive(enc_i(12'd5, 0, 0, 1, 7'b0010011), 32'h20);
    tick();
    i_ready = 1'b0;
    drive(enc_i(12'd9, 0, 0, 8, 7'b0010011), 32'h24);
    for (int c = 0; c < 3; c++) begin
      if (c == 2) i_flush = 1'b1;
      #1;
      chk("stall_ready", o_ready, 0);
      chk("stall_valid", o_valid, 1);
      chk("stall_imm", o_imm, 32'd5);
      chk("stall_rd", o_rd, 1);
      tick();
    end
    chk("flush_valid", o_valid, 0);
    i_flush = 1'b0;
    i_ready = 1'b1;
    i_valid = 1'b0;
    tick();

    // async reset mid-transfer
    drive(enc_j(21'h800, 1), 32'h200);
    tick();
    i_valid = 1'b0;
    chk("pre_rst_valid", o_valid, 1);
    chk("pre_rst_redir", o_redirect, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", o_valid, 0);
    chk("rst_mid_redir", o_redirect, 0);
    chk("rst_mid_rpc", o_redirect_pc, 0);
    chk("rst_mid_imm", o_imm, 0);
    chk("rst_mid_rd", o_rd, 0);
    chk("rst_mid_pc", o_pc, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(enc_i(12'd5, 0, 0, 1, 7'b0010011), 32'h0);
    tick();
    i_valid = 1'b0;
    chk("post_rst_valid", o_valid, 1);
    chk("post_rst_imm", o_imm, 32'd5);

    // 64-bit JALR wrap
    d_instr = enc_i(12'd2, 1, 0, 1, 7'b1100111);
    d_pc    = 64'h1000;
    d_rs1   = 64'hFFFF_FFFF_FFFF_FFFF;
    d_pred  = 1'b0;
    d_valid = 1'b1;
    tick();
    d_valid = 1'b0;
    chk("x64_valid", d_ovalid, 1);
    chk("x64_redirect", d_redirect, 1);
    chk("x64_rpc", d_redirect_pc, 64'h0);
    chk("x64_imm", d_imm, 64'h2);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_pipe.md
DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 Parameter XLEN, default 32, sets the datapath width; 32 and 64 are the only legal values.
REQ-002 Parameter NUM_FWD, default 2, sets the number of forwarding sources; legal range is 1..4.
REQ-003 Parameter HAS_BR_RESOLVE, default 1; when 0, o_redirect SHALL be tied low and branches/jumps SHALL pass through undecided.
REQ-004 Ports SHALL be as listed below; reset is rst_n, asynchronous, active-low; clock is clk.
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  fetch has an instruction
- o_ready  out  1  decode accepts this cycle
- i_instr  in  32  instruction word
- i_pc  in  XLEN  instruction PC
- i_pred_taken  in  1  fetch prediction
- o_rs1_addr, o_rs2_addr  out  5 each  register-file read addresses
- i_rs1_rdata, i_rs2_rdata  in  XLEN each  register-file read data
- i_fwd_valid  in  NUM_FWD  forward source valid; index 0 is youngest
- i_fwd_rd  in  5*NUM_FWD  forward destination registers
- i_fwd_data  in  XLEN*NUM_FWD  forward data
- i_ex_is_load, i_ex_rd  in  1, 5  load currently in EX
- i_flush  in  1  squash from a later stage
- o_redirect, o_redirect_pc  out  1, XLEN  fetch redirect
- o_valid  out  1  to EX
- i_ready  in  1  EX accepts
- o_rs1_data, o_rs2_data, o_imm  out  XLEN each  operands
- o_opcode, o_func3, o_alu_ctrl, o_rd  out  7, 3, 4, 5  decoded fields
- o_pc  out  XLEN  PC to EX
- o_illegal  out  1  unknown opcode

Function
REQ-005 Decode SHALL be combinational from i_instr; the immediate SHALL be sign-extended to XLEN for the I, S, B, U and J formats.
REQ-006 rs1 and rs2 SHALL count as "used" per opcode: U, UPC and J use neither; I, L and JALR use rs1 only; R, S and B use both.
REQ-007 Forwarded operand: the lowest-index source with i_fwd_valid set and i_fwd_rd equal to rsX (rsX != 0) SHALL be selected; otherwise i_rsX_rdata. x0 SHALL always read 0.
REQ-008 hazard = i_valid & i_ex_is_load & (i_ex_rd != 0) & (i_ex_rd matches a used rs1 or rs2).
REQ-009 o_ready = (!o_valid | i_ready) & !hazard; fire = i_valid & o_ready.
REQ-010 accept = fire & !o_redirect & !i_flush. An instruction that fires while o_redirect is high SHALL be dropped as wrong-path.
REQ-011 Output register, evaluated on each posedge in priority order:
- i_flush: o_valid <= 0.
- else if (!o_valid | i_ready): o_valid <= accept.
- The payload SHALL load only on accept.
- While o_valid & !i_ready, the payload SHALL be held stable.
REQ-012 A hazard cycle with i_ready high SHALL produce a bubble (o_valid=0) on the next cycle; latency from accept to o_valid is 1 cycle.
REQ-013 Branch resolution SHALL use the forwarded operands:
- B-type: BEQ, BNE, BLT, BGE, BLTU, BGEU; target = pc + imm.
- JAL: always taken, target = pc + imm.
- JALR: always taken, target = (rs1 + imm) & ~1.
REQ-014 mispredict = taken XOR i_pred_taken, for branch/jump opcodes only.
REQ-015 On posedge: o_redirect <= accept & mispredict; o_redirect_pc <= taken ? target : pc+4. Both SHALL be a one-cycle pulse, 1 cycle after accept.
REQ-016 When i_flush and fire occur in the same cycle, flush SHALL win: no o_valid, no redirect.
REQ-017 An unknown opcode SHALL set o_illegal=1 and o_alu_ctrl=0 and still pass through; it SHALL never redirect.
REQ-018 PC arithmetic SHALL wrap modulo 2^XLEN.

Reset
REQ-019 While rst_n is low, all of the following SHALL be 0:
- o_valid, o_redirect, o_redirect_pc
- all payload outputs, including o_illegal
REQ-020 A reset asserted mid-transfer SHALL discard the held instruction; the first accept is possible on the first clk edge after release.

Structure
REQ-021 Package decode_pkg SHALL hold the opcode constants, the ALU_CTRL encodings, the func3 branch codes, and NOP (32'h00000013).
REQ-022 Branch compare and target computation SHALL be one sub-module, branch_resolve, parameterised by XLEN.
REQ-023 The register file SHALL remain outside this block.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- ADDI x1,x0,5 with i_ready=1 -> next cycle o_valid=1, o_imm=5, o_rd=1, o_illegal=0.
- EX load to x3, then ADD x4,x3,x2 -> o_ready=0 for 1 cycle and one bubble; the instruction issues once the hazard clears.
- i_fwd_valid=2'b11, both rd=5, data0=0xAA, data1=0xBB, instr uses x5 -> operand equals 0xAA.
- BEQ x1,x2,+16 at pc 0x100, x1=x2, i_pred_taken=0 -> o_redirect pulses one cycle with o_redirect_pc=0x110; the next fired instruction is dropped.
- i_ready=0 for 3 cycles with o_valid=1 -> payload is unchanged and o_ready=0; i_flush in the 3rd cycle -> o_valid=0.
- Reset asserted while o_valid=1 -> all outputs are 0 immediately; with XLEN=64, JALR x1 with rs1=0xFFFF_FFFF_FFFF_FFFF and imm=2 -> o_redirect_pc=0x0.
